rll_keyed_pipe: RTL and testbench



---
 rtl/rll_pkg.sv | 24 ++
 rtl/rll_pipe_stage.sv | 39 +++
 rtl/rll_keyed_pipe.sv | 156 +++++++++++++++
 tb/tb_rll_keyed_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rll_pkg.sv
// Shared definitions for the keyed RLL pipeline: FSM state encoding and width limits.
// RLL_KEY_PARITY_EN adds the PARITY/ERROR states used by the serial key parity check.
package rll_pkg;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_STAGES = 8;

`ifdef RLL_KEY_PARITY_EN
  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_LOADING,
    ST_ARMED,
    ST_PARITY,
    ST_ERROR
  } rll_state_t;
`else
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOADING,
    ST_ARMED
  } rll_state_t;
`endif

endpackage

// File: rtl/rll_pipe_stage.sv
// One valid/ready register slice; loads when empty or when its current word leaves this cycle.
// flush drops the held word synchronously.
module rll_pipe_stage
  import rll_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_width
    $error("rll_pipe_stage: DATA_W out of range");
  end

  logic load;
  assign load = in_valid && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rll_keyed_pipe.sv
// Logic-locked datapath: a serially loaded key unlocks words which then flow through a
// STAGES-deep valid/ready pipeline. Optional macro RLL_KEY_PARITY_EN adds key parity checking.
module rll_keyed_pipe
  import rll_pkg::*;
#(
  parameter int unsigned      DATA_W  = 32,
  parameter int unsigned      KEY_W   = 32,
  parameter logic [KEY_W-1:0] KEY_POL = '0,
  parameter int unsigned      STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_in_valid,
  input  logic              key_in_bit,
  output logic              key_in_ready,
  input  logic              key_clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
`ifdef RLL_KEY_PARITY_EN
  output logic              key_err,
`endif
  output logic              key_loaded
);

  if (DATA_W < 8 || DATA_W > MAX_DATA_W || KEY_W < 1 || KEY_W > DATA_W ||
      STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_param
    $error("rll_keyed_pipe: parameter out of range");
  end

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  rll_state_t       state_q, state_d;
  logic [KEY_W-1:0] key_q, key_shifted;
  logic [CNT_W-1:0] cnt_q;
  logic             key_acc, shift_en, last_bit, armed;

  assign key_acc  = key_in_valid && key_in_ready && !key_clear;
  assign last_bit = (cnt_q == CNT_W'(KEY_W - 1));
  assign armed    = (state_q == ST_ARMED);

  // Bits enter at the MSB so the first bit sent ends up at bit 0.
  if (KEY_W == 1) begin : g_key1
    assign key_shifted = key_in_bit;
  end else begin : g_keyn
    assign key_shifted = {key_in_bit, key_q[KEY_W-1:1]};
  end

`ifdef RLL_KEY_PARITY_EN
  assign shift_en = key_acc && (state_q != ST_PARITY);
  assign key_err  = (state_q == ST_ERROR);
`else
  assign shift_en = key_acc;
`endif

  always_comb begin
    state_d      = state_q;
    key_in_ready = 1'b0;
    key_loaded   = 1'b0;
    case (state_q)
      ST_EMPTY, ST_LOADING: begin
        key_in_ready = 1'b1;
        if (key_acc) begin
          if (last_bit) begin
`ifdef RLL_KEY_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_ARMED;
`endif
          end else begin
            state_d = ST_LOADING;
          end
        end
      end
      ST_ARMED: key_loaded = 1'b1;
`ifdef RLL_KEY_PARITY_EN
      ST_PARITY: begin
        key_in_ready = 1'b1;
        // Even parity: the extra bit must equal the XOR of all key bits.
        if (key_acc) state_d = (key_in_bit == ^key_q) ? ST_ARMED : ST_ERROR;
      end
      ST_ERROR: ;
`endif
      default: state_d = ST_EMPTY;
    endcase
    if (key_clear) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (key_clear) begin
        key_q <= '0;
        cnt_q <= '0;
      end else if (shift_en) begin
        key_q <= key_shifted;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  logic [DATA_W-1:0] lock_mask;
  always_comb begin
    lock_mask            = '0;
    lock_mask[KEY_W-1:0] = key_q ^ KEY_POL;
  end

  logic [STAGES-1:0] vin, vout, rdy_next;
  logic [DATA_W-1:0] din  [STAGES];
  logic [DATA_W-1:0] dout [STAGES];

  assign vin[0] = in_valid && armed;
  assign din[0] = in_data ^ lock_mask;

  // Ready for each stage's output, unrolled from the sink so no signal feeds back on itself.
  always_comb begin
    logic acc;
    int unsigned idx;
    rdy_next = '0;
    acc      = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      idx           = STAGES - 1 - i;
      rdy_next[idx] = acc;
      acc           = acc || !vout[idx];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g > 0) begin : g_link
      assign vin[g] = vout[g-1];
      assign din[g] = dout[g-1];
    end
    rll_pipe_stage #(.DATA_W(DATA_W)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (key_clear),
      .in_valid  (vin[g]),
      .in_data   (din[g]),
      .out_valid (vout[g]),
      .out_data  (dout[g]),
      .out_ready (rdy_next[g])
    );
  end

  assign in_ready  = armed && (!vout[0] || rdy_next[0]);
  assign out_valid = vout[STAGES-1];
  assign out_data  = dout[STAGES-1];

endmodule

// File: tb/tb_rll_keyed_pipe.sv
// Scoreboard bench for rll_keyed_pipe (DATA_W=8, KEY_W=8, KEY_POL=8'hA5, STAGES=2).
module tb_rll_keyed_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_in_valid, key_in_bit, key_in_ready, key_clear;
  logic       in_valid, in_ready, out_valid, out_ready, key_loaded;
  logic [7:0] in_data, out_data;
`ifdef RLL_KEY_PARITY_EN
  logic       key_err;
`endif

  rll_keyed_pipe #(
    .DATA_W (8),
    .KEY_W  (8),
    .KEY_POL(8'hA5),
    .STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in_valid(key_in_valid),
    .key_in_bit  (key_in_bit),
    .key_in_ready(key_in_ready),
    .key_clear   (key_clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
`ifdef RLL_KEY_PARITY_EN
    .key_err     (key_err),
`endif
    .key_loaded  (key_loaded)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    int unsigned t_acc;
    bit          lat;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares every transfer, and checks hold stability under backpressure.
  bit         hold_prev = 1'b0;
  logic [7:0] data_prev;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (hold_prev && out_valid) check("out_stable", out_data, data_prev);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got 0x%0h, expected no output (t=%0t)", out_data, $time);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          if (e.lat) check("latency", cyc - e.t_acc, 2);
        end
      end
      hold_prev = out_valid && !out_ready;
      data_prev = out_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic send(input logic [7:0] w, input logic [7:0] exp, input bit lat, input bit track);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (track) sb.push_back('{data: exp, t_acc: cyc, lat: lat});
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance of 0x%0h", w);
    in_valid = 1'b0;
  endtask

  task automatic load_key(input logic [7:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      key_in_valid = 1'b1;
      key_in_bit   = k[i];
      @(negedge clk);
      check("key_in_ready", key_in_ready, 1);
      @(posedge clk); #1;
    end
    key_in_valid = 1'b0;
  endtask

  task automatic parity_bit(input logic [7:0] k);
`ifdef RLL_KEY_PARITY_EN
    logic [7:0] p;
    p = {7'b0, ^k};
    load_key(p, 1);
`else
    if (k === 8'hxx) $display("unused");
`endif
  endtask

  task automatic pulse_clear();
    key_clear = 1'b1;
    @(posedge clk); #1;
    key_clear = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end within 200000 time units");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; key_in_valid = 1'b0; key_in_bit = 1'b0; key_clear = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_key_loaded", key_loaded, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_key_in_ready", key_in_ready, 1);
    check("rel_in_ready", in_ready, 0);
    check("rel_key_loaded", key_loaded, 0);
    check("rel_out_valid", out_valid, 0);
    check("rel_out_data", out_data, 0);
    @(posedge clk); #1;

    // Correct key: transparent passthrough with 2-cycle latency.
    load_key(8'hA5, 7);
    check("loaded_after7", key_loaded, 0);
    load_key(8'h01, 1);
    parity_bit(8'hA5);
    check("loaded_after8", key_loaded, 1);
    check("armed_key_in_ready", key_in_ready, 0);
    check("armed_in_ready", in_ready, 1);
    send(8'h3C, 8'h3C, 1, 1);
    in_valid = 1'b0;
    wait_drain();

    // Key bits in ARMED are ignored.
    key_in_valid = 1'b1; key_in_bit = 1'b1;
    repeat (3) @(posedge clk);
    #1 key_in_valid = 1'b0;
    check("armed_ignore_loaded", key_loaded, 1);
    send(8'hF0, 8'hF0, 1, 1);
    in_valid = 1'b0;
    wait_drain();

    // key_clear with two words in flight beats simultaneous key bit and word.
    out_ready = 1'b0;
    send(8'h11, 8'h00, 0, 0);
    send(8'h22, 8'h00, 0, 0);
    in_valid = 1'b1; in_data = 8'h33;
    key_in_valid = 1'b1; key_in_bit = 1'b1;
    pulse_clear();
    in_valid = 1'b0; key_in_valid = 1'b0;
    check("clr_out_valid", out_valid, 0);
    check("clr_key_loaded", key_loaded, 0);
    check("clr_in_ready", in_ready, 0);
    check("clr_key_in_ready", key_in_ready, 1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Wrong key 0x00: every data bit flipped by KEY_POL.
    load_key(8'h00, 8);
    parity_bit(8'h00);
    check("k00_loaded", key_loaded, 1);
    send(8'h3C, 8'h99, 1, 1);
    send(8'hFF, 8'h5A, 1, 1);
    in_valid = 1'b0;
    wait_drain();

    // Back-to-back burst with 3 cycles of backpressure.
    pulse_clear();
    load_key(8'hA5, 8);
    parity_bit(8'hA5);
    out_ready = 1'b0;
    fork
      begin
        send(8'h01, 8'h01, 0, 1);
        send(8'h02, 8'h02, 0, 1);
        send(8'h03, 8'h03, 0, 1);
        send(8'h04, 8'h04, 0, 1);
        in_valid = 1'b0;
      end
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    wait_drain();

`ifdef RLL_KEY_PARITY_EN
    pulse_clear();
    load_key(8'hA5, 8);
    load_key(8'h01, 1);
    check("par_key_err", key_err, 1);
    check("par_in_ready", in_ready, 0);
    check("par_key_in_ready", key_in_ready, 0);
    pulse_clear();
    check("par_clr_key_err", key_err, 0);
    check("par_clr_key_in_ready", key_in_ready, 1);
`endif

    // Reset mid-load discards the partial key.
    pulse_clear();
    load_key(8'hA5, 5);
    rst_n = 1'b0;
    #3;
    check("midrst_key_loaded", key_loaded, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_key_in_ready", key_in_ready, 1);
    load_key(8'hA5, 8);
    parity_bit(8'hA5);
    check("reload_loaded", key_loaded, 1);
    send(8'h3C, 8'h3C, 1, 1);
    in_valid = 1'b0;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
